// File: rtl/knn_neighbor_selector.sv
// -----------------------------------------------------------------------------
// knn_neighbor_selector
//
// Consumer end of the KNN distance stream. Requests one training-sample
// distance at a time from the distance calculator (calc_ready / dist_done
// handshake). It keeps the K smallest distances and their class labels in an
// ascending list. After the last sample it runs a majority vote and presents
// the winning class with a one-cycle result_valid pulse.
//
// Parameters:
//   K           neighbours kept (1 <= K <= NUM_TRAIN)
//   W           distance / class-label width
//   NUM_TRAIN   training samples per classification (>= 1)
//   NUM_CLASSES labels 0..NUM_CLASSES-1 are valid
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a classification (only looked at while idle)
//   dist_done         calculator result strobe; distance/data_type valid
//   distance          squared distance of the current training sample
//   data_type         class label of the current training sample
//   calc_ready        one-cycle request for the next sample
//   busy              high from accepted start through the result cycle
//   predicted_class   vote winner, all ones when no neighbour was kept
//   nearest_distance  closest kept distance, all ones when list is empty
//   result_valid      one-cycle pulse, result outputs valid
// -----------------------------------------------------------------------------
module knn_neighbor_selector #(
  parameter int K           = 3,
  parameter int W           = 16,
  parameter int NUM_TRAIN   = 8,
  parameter int NUM_CLASSES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dist_done,
  input  logic [W-1:0] distance,
  input  logic [W-1:0] data_type,
  output logic         calc_ready,
  output logic         busy,
  output logic [W-1:0] predicted_class,
  output logic [W-1:0] nearest_distance,
  output logic         result_valid
);

  // The counter only ever holds 0..NUM_TRAIN-1 before leaving COLLECT.
  localparam int CNT_W = (NUM_TRAIN > 1) ? $clog2(NUM_TRAIN) : 1;
  localparam int VC_W  = $clog2(K + 1);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_TRAIN - 1);
  // One extra bit so NUM_CLASSES == 2^W is representable.
  localparam logic [W:0]       CLASS_LIMIT = (W + 1)'(NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VOTE,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             calc_ready_reg, calc_ready_next;

  // Neighbour list, ascending by distance. Entries are held in flops because
  // every slot may shift in the same cycle.
  logic [W-1:0]     dist_reg [K];
  logic [W-1:0]     type_reg [K];
  logic [K-1:0]     occ_reg;

  logic [W-1:0]     predicted_class_reg;
  logic [W-1:0]     nearest_distance_reg;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      calc_ready_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      calc_ready_reg <= calc_ready_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    calc_ready_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next      = COLLECT;
          count_next      = '0;
          calc_ready_next = 1'b1;
        end
      end
      COLLECT: begin
        if (dist_done) begin
          count_next = count_reg + CNT_W'(1);
          if (count_reg == LAST_IDX) begin
            state_next = VOTE;
          end else begin
            calc_ready_next = 1'b1;
          end
        end
      end
      VOTE:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sorted insertion
  // ---------------------------------------------------------------------------
  logic         clear_list;
  logic         label_ok;
  logic         insert_en;
  logic [K-1:0] closer;          // distance strictly below slot's distance
  logic [W-1:0] ins_dist [K];
  logic [W-1:0] ins_type [K];
  logic [K-1:0] ins_occ;

  assign clear_list = (state_reg == IDLE) && start;
  assign label_ok   = ({1'b0, data_type} < CLASS_LIMIT);
  // Because the list is ascending, beating the last slot means a slot exists.
  assign insert_en  = (state_reg == COLLECT) && dist_done && closer[K-1] && label_ok;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      assign closer[gi] = (distance < dist_reg[gi]);
      if (gi == 0) begin : g_head
        assign ins_dist[gi] = distance;
        assign ins_type[gi] = data_type;
        assign ins_occ[gi]  = 1'b1;
      end else begin : g_body
        // closer[] is monotonic along the list: a slot takes the new sample
        // only if it is the first one beaten, otherwise it inherits its upper
        // neighbour. Strict compare keeps earlier equal samples ahead.
        assign ins_dist[gi] = closer[gi-1] ? dist_reg[gi-1] : distance;
        assign ins_type[gi] = closer[gi-1] ? type_reg[gi-1] : data_type;
        assign ins_occ[gi]  = closer[gi-1] ? occ_reg[gi-1]  : 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      if (rst || clear_list) begin
        dist_reg[i] <= '1;
        type_reg[i] <= '0;
        occ_reg[i]  <= 1'b0;
      end else if (insert_en && closer[i]) begin
        dist_reg[i] <= ins_dist[i];
        type_reg[i] <= ins_type[i];
        occ_reg[i]  <= ins_occ[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Majority vote
  // Each slot counts how many occupied slots share its label. Scanning slots
  // from nearest to farthest and only replacing on a strictly larger count
  // resolves class ties in favour of the class seen nearest first.
  // ---------------------------------------------------------------------------
  logic [VC_W-1:0] votes [K];
  logic [VC_W-1:0] best_votes;
  logic [W-1:0]    winner;

  generate
    for (gi = 0; gi < K; gi++) begin : g_vote
      logic [VC_W-1:0] tally;
      always_comb begin
        tally = '0;
        for (int j = 0; j < K; j++) begin
          if (occ_reg[gi] && occ_reg[j] && (type_reg[j] == type_reg[gi])) begin
            tally = tally + VC_W'(1);
          end
        end
      end
      assign votes[gi] = tally;
    end
  endgenerate

  always_comb begin
    best_votes = '0;
    winner     = '1;             // empty list reports all ones
    for (int i = 0; i < K; i++) begin
      if (votes[i] > best_votes) begin
        best_votes = votes[i];
        winner     = type_reg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      predicted_class_reg  <= '0;
      nearest_distance_reg <= '0;
    end else if (state_reg == VOTE) begin
      predicted_class_reg  <= winner;
      nearest_distance_reg <= dist_reg[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign calc_ready       = calc_ready_reg;
  assign busy             = (state_reg != IDLE);
  assign result_valid     = (state_reg == DONE);
  assign predicted_class  = predicted_class_reg;
  assign nearest_distance = nearest_distance_reg;

endmodule

// File: tb/tb_knn_neighbor_selector.sv
`timescale 1ns/1ps
module tb_knn_neighbor_selector;

  localparam int W  = 16;
  localparam int K  = 3;
  localparam int NT = 5;
  localparam int NC = 4;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] t;
  } samp_t;

  typedef struct packed {
    logic [15:0] cls;
    logic [15:0] near;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, dist_done = 1'b0;
  logic [W-1:0]  distance = '0, data_type = '0;
  logic          calc_ready, busy, result_valid;
  logic [W-1:0]  predicted_class, nearest_distance;

  logic          start_e = 1'b0, dist_done_e = 1'b0;
  logic [W-1:0]  distance_e = '0, data_type_e = '0;
  logic          calc_ready_e, busy_e, result_valid_e;
  logic [W-1:0]  predicted_class_e, nearest_distance_e;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    cr_pulses = 0;
  exp_t  sb[$];
  samp_t stim[$];
  exp_t  mon_e;

  knn_neighbor_selector #(.K(K), .W(W), .NUM_TRAIN(NT), .NUM_CLASSES(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .dist_done(dist_done),
    .distance(distance), .data_type(data_type), .calc_ready(calc_ready),
    .busy(busy), .predicted_class(predicted_class),
    .nearest_distance(nearest_distance), .result_valid(result_valid)
  );

  knn_neighbor_selector #(.K(1), .W(W), .NUM_TRAIN(1), .NUM_CLASSES(NC)) dut_edge (
    .clk(clk), .rst(rst), .start(start_e), .dist_done(dist_done_e),
    .distance(distance_e), .data_type(data_type_e), .calc_ready(calc_ready_e),
    .busy(busy_e), .predicted_class(predicted_class_e),
    .nearest_distance(nearest_distance_e), .result_valid(result_valid_e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (calc_ready === 1'b1) cr_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: drop invalid labels and unbeatable distances, stable-sort by
  // distance, keep the first k, then vote per class with nearest-first ties.
  function automatic void ref_model(input samp_t s[$], input int k,
                                    output logic [15:0] cls, output logic [15:0] near);
    samp_t kept[$];
    samp_t tmp;
    int cnt[NC];
    int first[NC];
    int best_c, best_n, best_f;
    foreach (s[i]) if (s[i].t < NC && s[i].d != 16'hFFFF) kept.push_back(s[i]);
    for (int i = 0; i < kept.size(); i++)
      for (int j = 0; j + 1 < kept.size() - i; j++)
        if (kept[j].d > kept[j+1].d) begin
          tmp = kept[j]; kept[j] = kept[j+1]; kept[j+1] = tmp;
        end
    while (kept.size() > k) void'(kept.pop_back());
    near = (kept.size() > 0) ? kept[0].d : 16'hFFFF;
    for (int c = 0; c < NC; c++) begin cnt[c] = 0; first[c] = k; end
    foreach (kept[i]) begin
      cnt[kept[i].t]++;
      if (first[kept[i].t] > i) first[kept[i].t] = i;
    end
    best_c = -1; best_n = 0; best_f = k;
    for (int c = 0; c < NC; c++)
      if (cnt[c] > 0 && (cnt[c] > best_n || (cnt[c] == best_n && first[c] < best_f))) begin
        best_c = c; best_n = cnt[c]; best_f = first[c];
      end
    cls = (best_c < 0) ? 16'hFFFF : 16'(best_c);
  endfunction

  // Monitor: every result pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_result_valid: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("predicted_class", predicted_class, mon_e.cls);
        check("nearest_distance", nearest_distance, mon_e.near);
        check("result_cycle", cyc, mon_e.cyc);
        check("busy_with_valid", busy, 1);
      end
    end
  end

  task automatic sp(input int d, input int t);
    stim.push_back('{d: 16'(d), t: 16'(t)});
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (calc_ready !== 1'b1 && n < 20) begin tick(); n++; end
    ok = (calc_ready === 1'b1);
    check("calc_ready_arrives", calc_ready, 1);
  endtask

  // Drive one classification from stim; expectation is pushed at the last sample.
  task automatic run_class(input bit fixed, input logic [15:0] ecls,
                           input logic [15:0] enear, input bit poke);
    bit ok;
    int u;
    logic [15:0] mc, mn;
    exp_t e;
    start = 1'b1; tick(); start = 1'b0;
    check("busy_after_start", busy, 1);
    check("calc_ready_after_start", calc_ready, 1);
    for (int i = 0; i < stim.size(); i++) begin
      wait_ready(ok);
      if (!ok) return;
      repeat ($urandom_range(0, 2)) tick();
      start = poke; distance = stim[i].d; data_type = stim[i].t; dist_done = 1'b1;
      u = cyc;
      if (i == stim.size() - 1) begin
        if (fixed) begin mc = ecls; mn = enear; end
        else ref_model(stim, K, mc, mn);
        e.cls = mc; e.near = mn; e.cyc = u + 2;
        sb.push_back(e);
      end
      tick(); dist_done = 1'b0; start = 1'b0;
    end
    check("busy_in_vote", busy, 1);
    check("valid_not_early", result_valid, 0);
    tick(); start = poke;        // result cycle: a start here must be ignored
    tick(); start = 1'b0;
    check("busy_falls", busy, 0);
    check("no_restart_from_done", calc_ready, 0);
  endtask

  task automatic run_edge(input logic [15:0] d, input logic [15:0] t);
    samp_t one[$];
    logic [15:0] mc, mn;
    one.push_back('{d: d, t: t});
    ref_model(one, 1, mc, mn);
    start_e = 1'b1; tick(); start_e = 1'b0;
    check("edge_calc_ready", calc_ready_e, 1);
    distance_e = d; data_type_e = t; dist_done_e = 1'b1;
    tick(); dist_done_e = 1'b0;
    check("edge_valid_u1", result_valid_e, 0);
    tick();
    check("edge_valid_u2", result_valid_e, 1);
    check("edge_predicted_class", predicted_class_e, mc);
    check("edge_nearest_distance", nearest_distance_e, mn);
    tick();
    check("edge_busy_falls", busy_e, 0);
    check("edge_valid_drops", result_valid_e, 0);
  endtask

  initial begin
    bit ok;
    int cr0, n;
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    check("reset_calc_ready", calc_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_predicted_class", predicted_class, 0);
    check("reset_nearest_distance", nearest_distance, 0);

    // Stray dist_done while idle
    distance = 16'd1; data_type = 16'd1; dist_done = 1'b1; tick(); dist_done = 1'b0;
    check("stray_done_calc_ready", calc_ready, 0);
    check("stray_done_busy", busy, 0);

    stim.delete(); sp(10,1); sp(4,2); sp(7,1); sp(20,3); sp(5,2);
    run_class(1'b1, 16'd2, 16'd4, 1'b1);
    stim.delete(); sp(9,2); sp(3,0); sp(6,1); sp(30,3); sp(40,3);
    run_class(1'b1, 16'd0, 16'd3, 1'b0);
    stim.delete(); sp(5,1); sp(5,2); sp(5,2); sp(5,3); sp(5,3);
    run_class(1'b1, 16'd2, 16'd5, 1'b1);
    cr0 = cr_pulses;
    stim.delete(); sp(1,7); sp(2,3); sp(50,3); sp(60,0); sp(70,0);
    run_class(1'b1, 16'd3, 16'd2, 1'b0);
    check("calc_ready_pulses", cr_pulses - cr0, 5);
    stim.delete(); sp(5,4); sp(6,7); sp(7,5); sp(8,9); sp(9,4);
    run_class(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);

    // Reset after the second sample, with a dist_done in the reset cycle
    start = 1'b1; tick(); start = 1'b0;
    wait_ready(ok); distance = 16'd10; data_type = 16'd1; dist_done = 1'b1; tick(); dist_done = 1'b0;
    wait_ready(ok); distance = 16'd4;  data_type = 16'd2; dist_done = 1'b1; tick(); dist_done = 1'b0;
    wait_ready(ok);
    rst = 1'b1; distance = 16'd0; data_type = 16'd0; dist_done = 1'b1;
    tick(); rst = 1'b0; dist_done = 1'b0;
    check("rst_calc_ready", calc_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_predicted_class", predicted_class, 0);
    check("rst_nearest_distance", nearest_distance, 0);
    tick();
    check("rst_stays_idle", busy, 0);
    stim.delete(); sp(10,1); sp(4,2); sp(7,1); sp(20,3); sp(5,2);
    run_class(1'b1, 16'd2, 16'd4, 1'b0);

    // Randomized runs against the reference model
    for (int r = 0; r < 25; r++) begin
      stim.delete();
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(0, 15) == 0) sp(16'hFFFF, $urandom_range(0, 5));
        else sp($urandom_range(0, 40), $urandom_range(0, 5));
      end
      run_class(1'b0, 16'h0, 16'h0, 1'($urandom_range(0, 1)));
    end

    // K=1, NUM_TRAIN=1 instance
    run_edge(16'd8, 16'd3);
    for (int r = 0; r < 4; r++) run_edge(16'($urandom_range(0, 100)), 16'($urandom_range(0, 5)));

    n = 0;
    while (sb.size() > 0 && n < 20) begin tick(); n++; end
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
